// File: rtl/mult32x32_arbiter.sv
// Round-robin arbiter sharing a single mult32x32 unit between NREQ requesters.
// Sequences each op (latch, start pulse, busy tracking, capture) and returns a one-cycle response.
module mult32x32_arbiter #(
    parameter int unsigned NREQ        = 4,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [NREQ*32-1:0]   req_a,
    input  logic [NREQ*32-1:0]   req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      resp_valid,
    output logic [63:0]          resp_product,
    output logic                 resp_err,
    output logic                 arb_busy,
    output logic                 mult_start,
    output logic [31:0]          mult_a,
    output logic [31:0]          mult_b,
    input  logic                 mult_busy,
    input  logic [63:0]          mult_product
);

    localparam int unsigned IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CNTW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_RESP
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDW-1:0]    r_rr_ptr;
    logic [IDW-1:0]    r_gnt_id;
    logic [CNTW-1:0]   r_cnt;
    logic [31:0]       r_a;
    logic [31:0]       r_b;
    logic [63:0]       r_resp_product;
    logic [NREQ-1:0]   r_req_ready;
    logic [NREQ-1:0]   r_resp_valid;
    logic              r_resp_err;
    logic              r_arb_busy;
    logic              r_mult_start;

    logic              w_any;
    logic [IDW-1:0]    w_gnt_id;
    logic [31:0]       w_gnt_a;
    logic [31:0]       w_gnt_b;
    logic [CNTW-1:0]   w_cnt_inc;
    logic              w_timeout;
    logic [NREQ-1:0]   w_req_ready_nxt;
    logic [NREQ-1:0]   w_resp_valid_nxt;
    logic              w_resp_err_nxt;
    logic              w_arb_busy_nxt;
    logic              w_mult_start_nxt;

    // First requester at or after rr_ptr, wrapping at NREQ-1
    always_comb begin
        int unsigned j;
        w_any    = 1'b0;
        w_gnt_id = '0;
        j        = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            j = 32'(r_rr_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (!w_any && req_valid[IDW'(j)]) begin
                w_any    = 1'b1;
                w_gnt_id = IDW'(j);
            end
        end
    end

    assign w_gnt_a   = req_a[32*w_gnt_id +: 32];
    assign w_gnt_b   = req_b[32*w_gnt_id +: 32];
    assign w_cnt_inc = r_cnt + CNTW'(1);
    assign w_timeout = (w_cnt_inc == CNTW'(ACK_TIMEOUT));

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:      if (w_any) w_state_nxt = S_ISSUE;
            S_ISSUE:     w_state_nxt = S_WAIT_ACK;
            S_WAIT_ACK: begin
                if (mult_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end else if (w_timeout) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_WAIT_DONE: if (!mult_busy) w_state_nxt = S_RESP;
            S_RESP:      w_state_nxt = S_IDLE;
            default:     w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so the registered outputs align with the state
    always_comb begin
        w_req_ready_nxt  = '0;
        w_resp_valid_nxt = '0;
        w_resp_err_nxt   = 1'b0;
        w_mult_start_nxt = 1'b0;
        w_arb_busy_nxt   = (w_state_nxt != S_IDLE);
        case (w_state_nxt)
            S_ISSUE: begin
                w_mult_start_nxt          = 1'b1;
                w_req_ready_nxt[w_gnt_id] = 1'b1;
            end
            S_RESP: begin
                w_resp_valid_nxt[r_gnt_id] = 1'b1;
                w_resp_err_nxt             = (r_state == S_WAIT_ACK);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_err   <= 1'b0;
            r_arb_busy   <= 1'b0;
            r_mult_start <= 1'b0;
        end else begin
            r_req_ready  <= w_req_ready_nxt;
            r_resp_valid <= w_resp_valid_nxt;
            r_resp_err   <= w_resp_err_nxt;
            r_arb_busy   <= w_arb_busy_nxt;
            r_mult_start <= w_mult_start_nxt;
        end
    end

    // Operand/id latch, round-robin pointer, ack timeout counter, product capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr       <= '0;
            r_gnt_id       <= '0;
            r_cnt          <= '0;
            r_a            <= '0;
            r_b            <= '0;
            r_resp_product <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_gnt_id <= w_gnt_id;
                        r_a      <= w_gnt_a;
                        r_b      <= w_gnt_b;
                    end
                end
                S_ISSUE: begin
                    r_cnt    <= '0;
                    r_rr_ptr <= (r_gnt_id == IDW'(NREQ - 1)) ? '0 : r_gnt_id + IDW'(1);
                end
                S_WAIT_ACK: begin
                    if (!mult_busy) begin
                        r_cnt <= w_cnt_inc;
                        if (w_timeout) begin
                            r_resp_product <= '0;
                        end
                    end
                end
                S_WAIT_DONE: begin
                    if (!mult_busy) begin
                        r_resp_product <= mult_product;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready    = r_req_ready;
    assign resp_valid   = r_resp_valid;
    assign resp_product = r_resp_product;
    assign resp_err     = r_resp_err;
    assign arb_busy     = r_arb_busy;
    assign mult_start   = r_mult_start;
    assign mult_a       = r_a;
    assign mult_b       = r_b;

endmodule
